note_chart_player: RTL and testbench

Parametrised rhythm-game chart sequencer. Reads note events from an external chart ROM and spawns each note into a fixed pool of rectangle slots at its scheduled frame. It moves every live rectangle down the screen by a configurable speed each frame and retires it once it leaves the screen. Its packed rectangle bus replaces per-song hard-coded rectangle sets and feeds the existing renderer in the same `{X, Y, W, H}` format.

---
 rtl/note_chart_player.sv | 208 ++++++++++++++++++++
 tb/tb_note_chart_player.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/note_chart_player.sv
// Rhythm-game chart sequencer: spawns chart notes into a rectangle pool, scrolls and retires them.
// Latency: start to first spawn 1 frame; all state and the rectangle bus update on frame_clk edges.
// Backpressure: a due note waits (chart_addr holds, stall sets) while every slot is live.
module note_chart_player #(
    parameter int NUM_SLOTS  = 32,
    parameter int ADDR_W     = 8,
    parameter int TIME_W     = 16,
    parameter int SPEED      = 1,
    parameter int SCREEN_H   = 480,
    parameter int LANE_PITCH = 53,
    parameter int RECT_W     = 20
) (
    input  logic                     frame_clk,
    input  logic                     Reset,
    input  logic                     start,
    input  logic                     pause,
    output logic [ADDR_W-1:0]        chart_addr,
    input  logic [TIME_W+13:0]       chart_data,
    output logic [6:0]               numRectangles,
    output logic [NUM_SLOTS*43-1:0]  rectangles,
    output logic [6:0]               active_count,
    output logic                     playing,
    output logic                     done,
    output logic                     stall
);

    typedef enum logic [1:0] {IDLE, PLAY, DRAIN, DONE} state_t;

    localparam logic [9:0]         PITCH10 = 10'(LANE_PITCH);
    localparam logic [9:0]         WIDTH10 = 10'(RECT_W);
    localparam logic signed [13:0] SPD     = 14'(SPEED);
    localparam logic signed [13:0] LIMIT   = 14'(SCREEN_H);

    state_t state_q, state_d;

    logic [NUM_SLOTS-1:0] live_q, live_d;
    logic [9:0]           x_q [NUM_SLOTS];
    logic [9:0]           x_d [NUM_SLOTS];
    logic [12:0]          y_q [NUM_SLOTS];
    logic [12:0]          y_d [NUM_SLOTS];
    logic [9:0]           h_q [NUM_SLOTS];
    logic [9:0]           h_d [NUM_SLOTS];
    logic signed [13:0]   y_mv [NUM_SLOTS];

    logic [TIME_W-1:0] frame_q, frame_d;
    logic [ADDR_W-1:0] addr_d;
    logic              stall_d;
    logic [6:0]        count_d;
    logic              playing_d, done_d;

    logic [TIME_W-1:0]    note_frame;
    logic [3:0]           note_lane;
    logic [9:0]           note_len;
    logic [9:0]           spawn_x;
    logic [12:0]          spawn_y;
    logic [NUM_SLOTS-1:0] free_vec, free_sel;
    logic                 due, spawn;

    assign note_frame = chart_data[TIME_W+13:14];
    assign note_lane  = chart_data[13:10];
    assign note_len   = chart_data[9:0];

    // Multiply in 10 bits: the wrap matches truncating the full product.
    assign spawn_x = 10'(note_lane) * PITCH10;
    assign spawn_y = 13'd0 - {3'd0, note_len};

    // Free mask comes only from registered live bits; a slot freed this edge is usable next edge.
    assign free_vec = ~live_q;
    assign free_sel = free_vec & (~free_vec + NUM_SLOTS'(1));

    assign numRectangles = 7'(NUM_SLOTS);

    // Candidate next Y for each slot, one bit wider so the retire compare cannot wrap.
    always_comb begin
        for (int i = 0; i < NUM_SLOTS; i++) begin
            y_mv[i] = $signed({y_q[i][12], y_q[i]}) + SPD;
        end
    end

    // Next-state, motion, spawn and bookkeeping for the whole sequencer.
    always_comb begin
        state_d = state_q;
        live_d  = live_q;
        x_d     = x_q;
        y_d     = y_q;
        h_d     = h_q;
        addr_d  = chart_addr;
        frame_d = frame_q;
        stall_d = stall;

        due   = (state_q == PLAY) && !pause && (note_len != 10'd0) && (note_frame <= frame_q);
        spawn = due && (|free_vec);

        if ((state_q == PLAY || state_q == DRAIN) && !pause) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                if (live_q[i]) begin
                    if (y_mv[i] >= LIMIT) begin
                        live_d[i] = 1'b0;
                        x_d[i]    = 10'd0;
                        y_d[i]    = 13'd0;
                        h_d[i]    = 10'd0;
                    end else begin
                        y_d[i] = y_mv[i][12:0];
                    end
                end
            end
            if (frame_q != {TIME_W{1'b1}}) begin
                frame_d = frame_q + TIME_W'(1);
            end
        end

        // Only a free slot is selected, so the spawn never collides with motion above.
        if (spawn) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                if (free_sel[i]) begin
                    live_d[i] = 1'b1;
                    x_d[i]    = spawn_x;
                    y_d[i]    = spawn_y;
                    h_d[i]    = note_len;
                end
            end
            addr_d = chart_addr + ADDR_W'(1);
        end

        if (due && !(|free_vec)) begin
            stall_d = 1'b1;
        end

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = PLAY;
                    addr_d  = '0;
                    frame_d = '0;
                    stall_d = 1'b0;
                end
            end
            PLAY: begin
                if (note_len == 10'd0 || (spawn && chart_addr == {ADDR_W{1'b1}})) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (active_count == 7'd0) begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase

        count_d = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            count_d = count_d + 7'(live_d[i]);
        end

        playing_d = (state_d == PLAY) || (state_d == DRAIN);
        done_d    = (state_d == DONE);
    end

    // FSM state register.
    always_ff @(posedge frame_clk) begin
        if (Reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Slot pool, chart pointer, frame counter and registered status outputs.
    always_ff @(posedge frame_clk) begin
        if (Reset) begin
            live_q       <= '0;
            chart_addr   <= '0;
            frame_q      <= '0;
            stall        <= 1'b0;
            active_count <= '0;
            playing      <= 1'b0;
            done         <= 1'b0;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                x_q[i] <= '0;
                y_q[i] <= '0;
                h_q[i] <= '0;
            end
        end else begin
            live_q       <= live_d;
            chart_addr   <= addr_d;
            frame_q      <= frame_d;
            stall        <= stall_d;
            active_count <= count_d;
            playing      <= playing_d;
            done         <= done_d;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                x_q[i] <= x_d[i];
                y_q[i] <= y_d[i];
                h_q[i] <= h_d[i];
            end
        end
    end

    // Pack the renderer bus; free slots carry zeroed fields so nothing is drawn.
    always_comb begin
        rectangles = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            rectangles[(NUM_SLOTS-i)*43-1 -: 43] = {x_q[i], y_q[i], (live_q[i] ? WIDTH10 : 10'd0), h_q[i]};
        end
    end

endmodule

// File: tb/tb_note_chart_player.sv
module tb_note_chart_player;

    logic        frame_clk = 1'b0;
    logic        Reset, start, start2, pause;
    logic [7:0]  addr1, addr2;
    logic [29:0] data1, data2;
    logic [29:0] rom1 [256];
    logic [29:0] rom2 [256];
    logic [6:0]  num1, num2, act1, act2;
    logic [32*43-1:0] rect1;
    logic [2*43-1:0]  rect2;
    logic        play1, done1, stall1, play2, done2, stall2;

    int checks = 0;
    int errors = 0;

    always #5 frame_clk = ~frame_clk;

    assign data1 = rom1[addr1];
    assign data2 = rom2[addr2];

    note_chart_player dut1 (
        .frame_clk(frame_clk), .Reset(Reset), .start(start), .pause(pause),
        .chart_addr(addr1), .chart_data(data1), .numRectangles(num1),
        .rectangles(rect1), .active_count(act1), .playing(play1),
        .done(done1), .stall(stall1)
    );

    note_chart_player #(.NUM_SLOTS(2)) dut2 (
        .frame_clk(frame_clk), .Reset(Reset), .start(start2), .pause(pause),
        .chart_addr(addr2), .chart_data(data2), .numRectangles(num2),
        .rectangles(rect2), .active_count(act2), .playing(play2),
        .done(done2), .stall(stall2)
    );

    typedef struct {
        logic   st;
        integer act;
        integer addr;
        integer y0;
        integer y1;
        integer y2;
        integer play;
    } vec_t;

    vec_t tbl [10];

    task automatic chk(input string nm, input integer actual, input integer expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, actual, expected);
        end
    endtask

    task automatic step();
        @(posedge frame_clk);
        #1;
    endtask

    function automatic logic [29:0] note(input int f, input int lane, input int len);
        return {16'(f), 4'(lane), 10'(len)};
    endfunction

    function automatic logic [42:0] s1(input int i);
        return rect1[(32-i)*43-1 -: 43];
    endfunction

    function automatic logic [42:0] s2(input int i);
        return rect2[(2-i)*43-1 -: 43];
    endfunction

    function automatic integer fx(input logic [42:0] r);
        return r[42:33];
    endfunction

    function automatic integer fy(input logic [42:0] r);
        return $signed(r[32:20]);
    endfunction

    function automatic integer fw(input logic [42:0] r);
        return r[19:10];
    endfunction

    function automatic integer fh(input logic [42:0] r);
        return r[9:0];
    endfunction

    task automatic clear_roms();
        for (int i = 0; i < 256; i++) begin
            rom1[i] = '0;
            rom2[i] = '0;
        end
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        step();
        Reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        Reset  = 1'b1;
        start  = 1'b0;
        start2 = 1'b0;
        pause  = 1'b0;
        clear_roms();
        step();
        step();

        // Reset state
        chk("rst_rect_zero", integer'(rect1 != '0), 0);
        chk("rst_active", act1, 0);
        chk("rst_addr", addr1, 0);
        chk("rst_playing", play1, 0);
        chk("rst_done", done1, 0);
        chk("rst_stall", stall1, 0);
        chk("rst_num1", num1, 32);
        chk("rst_num2", num2, 2);
        Reset = 1'b0;

        // Three notes due at frame 5, table driven
        rom1[0] = note(5, 2, 15);
        rom1[1] = note(5, 4, 15);
        rom1[2] = note(5, 5, 15);
        rom1[3] = '0;
        tbl[0] = '{1'b1, 0, 0, 0, 0, 0, 1};
        tbl[1] = '{1'b0, 0, 0, 0, 0, 0, 1};
        tbl[2] = '{1'b0, 0, 0, 0, 0, 0, 1};
        tbl[3] = '{1'b0, 0, 0, 0, 0, 0, 1};
        tbl[4] = '{1'b0, 0, 0, 0, 0, 0, 1};
        tbl[5] = '{1'b0, 0, 0, 0, 0, 0, 1};
        tbl[6] = '{1'b0, 1, 1, -15, 0, 0, 1};
        tbl[7] = '{1'b0, 2, 2, -14, -15, 0, 1};
        tbl[8] = '{1'b0, 3, 3, -13, -14, -15, 1};
        tbl[9] = '{1'b0, 3, 3, -12, -13, -14, 1};
        for (int k = 0; k < 10; k++) begin
            start = tbl[k].st;
            step();
            start = 1'b0;
            chk($sformatf("tbl%0d_active", k), act1, tbl[k].act);
            chk($sformatf("tbl%0d_addr", k), addr1, tbl[k].addr);
            chk($sformatf("tbl%0d_y0", k), fy(s1(0)), tbl[k].y0);
            chk($sformatf("tbl%0d_y1", k), fy(s1(1)), tbl[k].y1);
            chk($sformatf("tbl%0d_y2", k), fy(s1(2)), tbl[k].y2);
            chk($sformatf("tbl%0d_playing", k), play1, tbl[k].play);
        end
        chk("tbl_x0", fx(s1(0)), 106);
        chk("tbl_x1", fx(s1(1)), 212);
        chk("tbl_x2", fx(s1(2)), 265);
        chk("tbl_w2", fw(s1(2)), 20);
        chk("tbl_h2", fh(s1(2)), 15);
        chk("tbl_slot3_free", integer'(s1(3)), 0);

        // Reset with five live notes, start held during reset is ignored, then replay
        do_reset();
        clear_roms();
        for (int i = 0; i < 5; i++) rom1[i] = note(0, i, 10);
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (5) step();
        chk("five_active", act1, 5);
        chk("five_addr", addr1, 5);
        Reset = 1'b1;
        start = 1'b1;
        step();
        Reset = 1'b0;
        chk("midrst_rect_zero", integer'(rect1 != '0), 0);
        chk("midrst_active", act1, 0);
        chk("midrst_playing", play1, 0);
        chk("midrst_addr", addr1, 0);
        step();
        start = 1'b0;
        chk("replay_playing", play1, 1);
        chk("replay_addr", addr1, 0);
        step();
        chk("replay_active", act1, 1);
        chk("replay_addr1", addr1, 1);
        chk("replay_y0", fy(s1(0)), -10);

        // Single note full lifetime
        do_reset();
        clear_roms();
        rom1[0] = note(0, 6, 30);
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        chk("life_e1_active", act1, 1);
        chk("life_e1_x", fx(s1(0)), 318);
        chk("life_e1_y", fy(s1(0)), -30);
        chk("life_e1_w", fw(s1(0)), 20);
        chk("life_e1_h", fh(s1(0)), 30);
        step();
        chk("life_e2_y", fy(s1(0)), -29);
        chk("life_e2_playing", play1, 1);
        repeat (508) step();
        chk("life_e510_y", fy(s1(0)), 479);
        chk("life_e510_active", act1, 1);
        step();
        chk("life_e511_active", act1, 0);
        chk("life_e511_slot_zero", integer'(s1(0)), 0);
        chk("life_e511_done", done1, 0);
        step();
        chk("life_e512_done", done1, 1);
        chk("life_e512_playing", play1, 0);

        // Start from DONE replays the chart
        rom1[0] = note(0, 1, 10);
        rom1[1] = '0;
        start = 1'b1;
        step();
        start = 1'b0;
        chk("redo_playing", play1, 1);
        chk("redo_done", done1, 0);
        step();
        chk("redo_active", act1, 1);
        chk("redo_x", fx(s1(0)), 53);

        // End marker at entry 0
        do_reset();
        clear_roms();
        start = 1'b1;
        step();
        start = 1'b0;
        chk("empty_e0_playing", play1, 1);
        step();
        chk("empty_e1_playing", play1, 1);
        chk("empty_e1_done", done1, 0);
        chk("empty_e1_active", act1, 0);
        step();
        chk("empty_e2_done", done1, 1);
        chk("empty_e2_playing", play1, 0);
        chk("empty_e2_addr", addr1, 0);

        // Pause freezes motion and spawning
        do_reset();
        clear_roms();
        rom1[0] = note(0, 1, 10);
        rom1[1] = note(10, 2, 10);
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (3) step();
        chk("pause_pre_y", fy(s1(0)), -8);
        pause = 1'b1;
        for (int k = 0; k < 20; k++) begin
            step();
            chk($sformatf("pause%0d_y", k), fy(s1(0)), -8);
            chk($sformatf("pause%0d_active", k), act1, 1);
        end
        pause = 1'b0;
        repeat (7) step();
        chk("unpause_e30_active", act1, 1);
        chk("unpause_e30_y0", fy(s1(0)), -1);
        step();
        chk("unpause_e31_active", act1, 2);
        chk("unpause_e31_y1", fy(s1(1)), -10);
        chk("unpause_e31_x1", fx(s1(1)), 106);
        chk("unpause_e31_y0", fy(s1(0)), 0);

        // Pool of two with three due notes
        do_reset();
        clear_roms();
        rom2[0] = note(0, 0, 60);
        rom2[1] = note(0, 1, 60);
        rom2[2] = note(0, 2, 60);
        start2 = 1'b1;
        step();
        start2 = 1'b0;
        chk("pool_e0_stall", stall2, 0);
        step();
        step();
        chk("pool_e2_active", act2, 2);
        chk("pool_e2_stall", stall2, 0);
        step();
        chk("pool_e3_stall", stall2, 1);
        chk("pool_e3_addr", addr2, 2);
        repeat (537) step();
        chk("pool_e540_active", act2, 2);
        chk("pool_e540_y0", fy(s2(0)), 479);
        step();
        chk("pool_e541_active", act2, 1);
        chk("pool_e541_slot0_zero", integer'(s2(0)), 0);
        chk("pool_e541_addr", addr2, 2);
        step();
        chk("pool_e542_active", act2, 1);
        chk("pool_e542_y0", fy(s2(0)), -60);
        chk("pool_e542_h0", fh(s2(0)), 60);
        chk("pool_e542_x0", fx(s2(0)), 106);
        chk("pool_e542_slot1_zero", integer'(s2(1)), 0);
        chk("pool_e542_addr", addr2, 3);
        chk("pool_e542_stall", stall2, 1);
        do_reset();
        chk("pool_rst_stall", stall2, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
